// File: rtl/axi_read_sched.sv
// Purpose: shares one AXI4 AR/R read channel between dsram, dcache, isram and icache
//          requesters with fixed priority (0 highest) and one burst outstanding; reads
//          whose line matches the in-flight write are held back until the write ends.
// Latency: request in IDLE at t -> arvalid at t+1; ack at t+1 if arready; rlast at t -> next arvalid at t+2.
// Backpressure: arvalid/fields held until arready; rready is high only while a burst is owned.
// Ports:
//   i_clk/i_rst_n              clock, synchronous active-low reset
//   i_req/i_addr/i_len/i_size  per-requester read request and AR fields
//   i_write_process/_address   in-flight write burst, used for the line hazard compare
//   o_ack/o_rvalid/o_rlast/o_rdata/o_rbeat  per-owner ack and beat delivery
//   o_len_err/o_busy           sticky burst-length error, scheduler busy
//   ar*/r*                     AXI4 AR and R channels
module axi_read_sched #(
  parameter int LINE_BYTE_OFFSET = 6,
  parameter int NREQ             = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ-1:0][31:0] i_addr,
  input  logic [NREQ-1:0][7:0]  i_len,
  input  logic [NREQ-1:0][2:0]  i_size,
  input  logic                  i_write_process,
  input  logic [31:0]           i_write_address,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_rvalid,
  output logic                  o_rlast,
  output logic [31:0]           o_rdata,
  output logic [7:0]            o_rbeat,
  output logic                  o_len_err,
  output logic                  o_busy,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic [2:0]       arsize_q, arsize_d;
  logic             arvalid_q, arvalid_d;
  logic [7:0]       rbeat_q, rbeat_d;
  logic             len_err_q, len_err_d;

  logic [NREQ-1:0]  elig;
  logic [IDX_W-1:0] win;
  logic             any_elig;
  logic             beat;

  // Only one burst is ever outstanding, so ID/response and the byte offset of the
  // write address carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, i_write_address[LINE_BYTE_OFFSET-1:0]};

  // Line-granular hazard: a read may not pass a write burst to the same line.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = i_req[k] &&
                !(i_write_process &&
                  (i_addr[k][31:LINE_BYTE_OFFSET] == i_write_address[31:LINE_BYTE_OFFSET]));
    end
  end

  // Scanning from the top down leaves the lowest eligible index as the winner.
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win      = IDX_W'(k);
        any_elig = 1'b1;
      end
    end
  end

  assign beat = (state_q == S_R) && rvalid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arvalid_d = arvalid_q;
    rbeat_d   = rbeat_q;
    len_err_d = len_err_q;
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          owner_d   = win;
          araddr_d  = i_addr[win];
          arlen_d   = i_len[win];
          arsize_d  = i_size[win];
          arvalid_d = 1'b1;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rbeat_d   = '0;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          rbeat_d = rbeat_q + 8'd1;
          if (rlast) begin
            if (rbeat_q != arlen_q) begin
              len_err_d = 1'b1;
            end
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arvalid_q <= 1'b0;
      rbeat_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arvalid_q <= arvalid_d;
      rbeat_q   <= rbeat_d;
      len_err_q <= len_err_d;
    end
  end

  assign arid    = 4'(owner_q);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (state_q == S_R);

  // Ack and beat delivery follow the AXI handshakes in the same cycle.
  assign o_ack     = (arvalid_q && arready) ? (NREQ'(1) << owner_q) : '0;
  assign o_rvalid  = beat ? (NREQ'(1) << owner_q) : '0;
  assign o_rlast   = beat && rlast;
  assign o_rdata   = beat ? rdata : 32'd0;
  assign o_rbeat   = rbeat_q;
  assign o_len_err = len_err_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_read_sched.sv
// Directed bench for axi_read_sched: arbitration/hazard vector table plus
// hand-written burst, backpressure, length-error and mid-burst reset sequences.
module tb_axi_read_sched;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [3:0]       i_req;
  logic [3:0][31:0] i_addr;
  logic [3:0][7:0]  i_len;
  logic [3:0][2:0]  i_size;
  logic             i_write_process;
  logic [31:0]      i_write_address;
  logic [3:0]       o_ack, o_rvalid;
  logic             o_rlast;
  logic [31:0]      o_rdata;
  logic [7:0]       o_rbeat;
  logic             o_len_err, o_busy;
  logic [3:0]       arid;
  logic [31:0]      araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic             arlock;
  logic [3:0]       arcache;
  logic [2:0]       arprot;
  logic             arvalid, arready;
  logic [3:0]       rid;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rlast, rvalid, rready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rlast_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_read_sched #(.LINE_BYTE_OFFSET(6), .NREQ(4)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .i_size(i_size), .i_write_process(i_write_process), .i_write_address(i_write_address),
    .o_ack(o_ack), .o_rvalid(o_rvalid), .o_rlast(o_rlast), .o_rdata(o_rdata),
    .o_rbeat(o_rbeat), .o_len_err(o_len_err), .o_busy(o_busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [3:0]  req;
    logic        wp;
    logic [31:0] waddr;
    logic        exp_vld;
    int          exp_id;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A cycle: inputs driven 1ns after the edge, outputs sampled 1ns later.
  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc_start();
    i_rst_n = 1'b0; i_req = '0; i_write_process = 1'b0; i_write_address = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    settle();
    cyc_start();
    i_rst_n = 1'b1;
    settle();
  endtask

  // Waits (bounded) for arvalid in the current or following cycles, checks the grant.
  task automatic wait_grant(input int exp_id, input int budget);
    int n = 0;
    while (arvalid !== 1'b1 && n < budget) begin
      cyc_start();
      settle();
      n++;
    end
    chk("grant_vld", arvalid, 1);
    chk("grant_id", arid, exp_id);
  endtask

  // Drives beats 0..last_beat (rlast on last_beat), then one idle cycle.
  task automatic do_burst(input int owner, input int last_beat, input logic [3:0] req_nxt);
    for (int b = 0; b <= last_beat; b++) begin
      cyc_start();
      i_req = req_nxt;
      rvalid = 1'b1; rlast = (b == last_beat);
      rdata = 32'hA000_0000 + (owner << 8) + b;
      settle();
      chk("beat_rvalid", o_rvalid, 64'(1) << owner);
      chk("beat_rbeat", o_rbeat, b & 255);
      chk("beat_rlast", o_rlast, (b == last_beat));
      chk("beat_rdata", o_rdata, 32'hA000_0000 + (owner << 8) + b);
      if (b == 0) begin
        chk("beat_rready", rready, 1);
        chk("beat_no_ack", o_ack, 0);
      end
      if (b == last_beat) last_rlast_cyc = cyc;
    end
    cyc_start();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    settle();
    chk("post_burst_busy", o_busy, 0);
    chk("post_burst_rvalid", o_rvalid, 0);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 32'h0000_0000, 1'b1, 0};
    vecs[1]  = '{4'b1111, 1'b0, 32'h0000_0000, 1'b1, 0};
    vecs[2]  = '{4'b1110, 1'b0, 32'h0000_0000, 1'b1, 1};
    vecs[3]  = '{4'b1100, 1'b0, 32'h0000_0000, 1'b1, 2};
    vecs[4]  = '{4'b1000, 1'b0, 32'h0000_0000, 1'b1, 3};
    vecs[5]  = '{4'b0000, 1'b0, 32'h0000_0000, 1'b0, 0};
    vecs[6]  = '{4'b0011, 1'b1, 32'h0000_1010, 1'b1, 1};
    vecs[7]  = '{4'b0011, 1'b0, 32'h0000_1010, 1'b1, 0};
    vecs[8]  = '{4'b0010, 1'b1, 32'h0000_2030, 1'b0, 0};
    vecs[9]  = '{4'b1010, 1'b1, 32'h0000_2030, 1'b1, 3};
    vecs[10] = '{4'b0010, 1'b1, 32'h0000_2040, 1'b1, 1};

    i_rst_n = 1'b0; i_req = 4'b1111; i_write_process = 1'b0; i_write_address = '0;
    for (int k = 0; k < 4; k++) begin
      i_addr[k] = (k + 1) * 32'h1000 + 4 * k;
      i_len[k]  = 8'(k + 1);
      i_size[k] = 3'd2;
    end
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hFFFF_FFFF;
    rid = '0; rresp = '0;

    // Reset values with busy-looking inputs.
    cyc_start(); cyc_start(); settle();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_arid", arid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rlast", o_rlast, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rbeat", o_rbeat, 0);
    chk("rst_len_err", o_len_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("const_arburst", arburst, 2'b01);
    chk("const_misc", {arlock, arcache, arprot}, 0);

    // Arbitration and hazard table: one IDLE evaluation per vector.
    for (int v = 0; v < 11; v++) begin
      do_reset();
      i_req = vecs[v].req; i_write_process = vecs[v].wp;
      i_write_address = vecs[v].waddr; arready = 1'b0;
      settle();
      cyc_start();
      i_req = '0;
      settle();
      chk("vec_arvalid", arvalid, vecs[v].exp_vld);
      chk("vec_busy", o_busy, vecs[v].exp_vld);
      if (vecs[v].exp_vld) begin
        chk("vec_arid", arid, vecs[v].exp_id);
        chk("vec_araddr", araddr, (vecs[v].exp_id + 1) * 32'h1000 + 4 * vecs[v].exp_id);
        chk("vec_arlen", arlen, vecs[v].exp_id + 1);
      end
    end

    // Single icache request, 16-beat burst.
    do_reset();
    i_addr[3] = 32'h1fc0_0000; i_len[3] = 8'd15; i_size[3] = 3'd2;
    i_req = 4'b1000; arready = 1'b1;
    settle();
    chk("single_idle_arvalid", arvalid, 0);
    cyc_start(); settle();
    chk("single_arvalid", arvalid, 1);
    chk("single_arid", arid, 3);
    chk("single_araddr", araddr, 32'h1fc0_0000);
    chk("single_arlen", arlen, 15);
    chk("single_arsize", arsize, 2);
    chk("single_ack", o_ack, 4'b1000);
    do_burst(3, 15, 4'b0000);
    chk("single_len_err", o_len_err, 0);

    // Priority: all four request together, short bursts.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_addr[k] = (k + 1) * 32'h1000 + 4 * k;
      i_len[k]  = 8'd1;
    end
    begin
      logic [3:0] pending;
      pending = 4'b1111;
      i_req = pending; arready = 1'b1;
      settle();
      for (int g = 0; g < 4; g++) begin
        wait_grant(g, 20);
        chk("prio_ack", o_ack, 64'(1) << g);
        if (g > 0) chk("prio_gap", cyc - last_rlast_cyc, 2);
        pending[g] = 1'b0;
        do_burst(g, 1, pending);
      end
    end

    // Hazard: dcache line matches the in-flight write, icache does not.
    do_reset();
    i_addr[1] = 32'h0000_1044; i_len[1] = 8'd0;
    i_addr[3] = 32'h0000_2000; i_len[3] = 8'd0;
    i_write_process = 1'b1; i_write_address = 32'h0000_1040;
    i_req = 4'b1010; arready = 1'b1;
    settle();
    wait_grant(3, 5);
    do_burst(3, 0, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc_start(); settle();
      chk("hazard_blocked", arvalid, 0);
    end
    cyc_start();
    i_write_process = 1'b0;
    settle();
    chk("hazard_release_same_cycle", arvalid, 0);
    cyc_start(); settle();
    chk("hazard_release_arvalid", arvalid, 1);
    chk("hazard_release_arid", arid, 1);
    chk("hazard_release_araddr", araddr, 32'h0000_1044);
    do_burst(1, 0, 4'b0000);

    // AR backpressure: arready low for 5 cycles.
    begin
      int acks;
      acks = 0;
      cyc_start();
      i_req = 4'b0001; i_addr[0] = 32'h0000_3000; i_len[0] = 8'd0; arready = 1'b0;
      settle();
      for (int i = 0; i < 5; i++) begin
        cyc_start();
        i_req = '0;
        settle();
        chk("bp_arvalid", arvalid, 1);
        chk("bp_araddr", araddr, 32'h0000_3000);
        if (o_ack != 0) acks++;
      end
      cyc_start();
      arready = 1'b1;
      settle();
      chk("bp_ack", o_ack, 4'b0001);
      if (o_ack != 0) acks++;
      do_burst(0, 0, 4'b0000);
      chk("bp_ack_count", acks, 1);
    end

    // Early rlast: arlen 3, rlast on beat 1.
    cyc_start();
    i_req = 4'b0100; i_addr[2] = 32'h0000_5000; i_len[2] = 8'd3;
    settle();
    wait_grant(2, 5);
    chk("early_ack", o_ack, 4'b0100);
    do_burst(2, 1, 4'b0000);
    chk("early_len_err", o_len_err, 1);
    cyc_start(); cyc_start(); settle();
    chk("early_len_err_sticky", o_len_err, 1);
    chk("early_idle", o_busy, 0);

    // Reset during beat 2 of an 8-beat dcache burst.
    cyc_start();
    i_req = 4'b0010; i_addr[1] = 32'h0000_6000; i_len[1] = 8'd7;
    settle();
    wait_grant(1, 5);
    for (int b = 0; b < 3; b++) begin
      cyc_start();
      i_req = '0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hB000_0000 + b;
      if (b == 2) i_rst_n = 1'b0;
      settle();
      chk("mid_rbeat", o_rbeat, b);
    end
    cyc_start();
    i_rst_n = 1'b1;
    settle();
    chk("mid_rst_rvalid", o_rvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_len_err", o_len_err, 0);
    chk("mid_rst_rbeat", o_rbeat, 0);
    chk("mid_rst_rdata", o_rdata, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_ar_fields", {arid, araddr, arlen}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_start(); settle();
      chk("mid_rst_no_beats", o_rvalid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_read_sched.md
# axi_read_sched

Read-channel scheduler that shares the single AXI4 AR/R channel between four read requesters: uncached data (dsram), dcache line refill, uncached instruction (isram) and icache line refill. It sits between the cache/uncached front-ends and the AXI master port, and keeps exactly one burst outstanding. It also blocks any read whose line is currently being written back by the write engine, so reads never overtake an in-flight write to the same line.

## Interface
Parameters:
- LINE_BYTE_OFFSET, 6: address bits below the line index; used for the write-hazard compare.
- NREQ, 4, fixed: requester index 0=dsram, 1=dcache, 2=isram, 3=icache. Also the priority order, 0 highest.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req  in  4  per-requester read request; held with stable fields until the matching o_ack.
- i_addr  in  4x32  per-requester start physical address.
- i_len  in  4x8  per-requester AXI arlen (beats-1).
- i_size  in  4x3  per-requester AXI arsize.
- i_write_process  in  1  write engine has a burst in flight.
- i_write_address  in  32  address of that in-flight write.
- o_ack  out  4  one-hot; pulses for the cycle of the AR handshake of the owner.
- o_rvalid  out  4  one-hot; data beat for the owner.
- o_rlast  out  1  last beat; qualified by any o_rvalid.
- o_rdata  out  32  beat data.
- o_rbeat  out  8  index of the current beat within the burst.
- o_len_err  out  1  sticky; rlast arrived at a beat index other than arlen.
- o_busy  out  1  state is not IDLE.
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out  AXI widths  AXI AR channel.
- arready  in  1  AXI AR ready.
- rid, rdata, rresp, rlast, rvalid  in  AXI widths  AXI R channel.
- rready  out  1  AXI R ready.

## Operation
- States: IDLE, AR, R.
- **IDLE**
  - Requester k is eligible when i_req[k] is high and it is not hazard-blocked.
  - Hazard-blocked means: i_write_process && i_addr[k][31:LINE_BYTE_OFFSET] == i_write_address[31:LINE_BYTE_OFFSET].
  - The lowest eligible index wins. Its index is latched as the owner. araddr, arlen and arsize are registered from that requester.
  - arid = owner index. arvalid = 1. Go to AR.
  - If no requester is eligible, stay in IDLE.
- **AR**
  - arvalid is held high with fields stable until arready.
  - On the handshake: o_ack[owner] = 1, o_rbeat cleared to 0, go to R.
- **R**
  - rready = 1.
  - Each rvalid beat drives o_rvalid[owner] = 1, o_rdata = rdata and o_rlast = rlast, all combinationally. o_rbeat increments after each beat.
  - On the beat with rlast: if o_rbeat != arlen, set o_len_err. Then go to IDLE and clear arvalid-related state.
  - rid and rresp are ignored; only one burst is ever outstanding.
- Constant AR fields: arburst = 2'b01 (INCR), arlock = 0, arcache = 0, arprot = 0.
- Requests are not re-sampled in AR or R. A request that stays asserted after its ack is treated as a new request on the next IDLE cycle. Requesters deassert i_req the cycle after they see o_ack.
- Fixed priority; starvation of icache under continuous higher-priority traffic is accepted.

## Timing
- Reset (i_rst_n low at a clock edge) forces:
  - state IDLE;
  - arvalid = 0, araddr = 0, arlen = 0, arsize = 0, arid = 0;
  - rready = 0;
  - o_ack = 0, o_rvalid = 0, o_rlast = 0, o_rdata = 0, o_rbeat = 0;
  - o_len_err = 0, o_busy = 0.
- Reset in the middle of a burst abandons it; remaining R beats after reset are not forwarded, because rready = 0.
- Request latency: request seen in IDLE at cycle t gives arvalid at t+1. With arready already high, o_ack occurs at t+1 and the first beat can be accepted at t+2.
- Back-to-back: rlast at cycle t puts the arbiter in IDLE at t+1 and the next arvalid at t+2.
- Simultaneous requests: the winner is decided in the IDLE cycle. Higher-priority requests arriving during AR or R wait for the next IDLE.
- Hazard release: if i_write_process drops at cycle t, the blocked request becomes eligible in the IDLE evaluation at cycle t.
- o_rbeat wraps modulo 256. An arlen of 255 is legal.

## Test plan
- **Single request.** Reset, then i_req = 4'b1000, i_addr[3] = 0x1fc0_0000, i_len[3] = 15, size 2, arready = 1.
  - Required: arvalid at +1 with arid = 3, araddr = 0x1fc0_0000, arlen = 15.
  - Required: o_ack = 4'b1000, then 16 beats on o_rvalid[3] with o_rbeat 0..15, o_rlast on beat 15, o_len_err = 0.
- **Priority.** i_req = 4'b1111 in the same cycle.
  - Required: grant order 0, 1, 2, 3 across four bursts; each grant's arvalid comes 2 cycles after the previous rlast.
- **Hazard.** i_write_process = 1, i_write_address = 0x0000_1040; dcache requests 0x0000_1044 and icache requests 0x0000_2000.
  - Required: icache is granted first; dcache is granted only after i_write_process falls.
- **AR backpressure.** arready held low for 5 cycles.
  - Required: arvalid and araddr stay stable for those 5 cycles; o_ack pulses exactly once, in the handshake cycle.
- **Early rlast.** arlen = 3 but rlast is sent on beat 1.
  - Required: o_len_err goes to 1 and stays 1; the arbiter returns to IDLE.
- **Reset mid-burst.** Assert i_rst_n = 0 during beat 2 of 8.
  - Required: all outputs return to their reset values on the next edge; no further o_rvalid pulses.
